comparator_stream_tx: RTL and testbench

- Transmitter side of the serial compare interface.
- Accepts two parallel operands through a valid/ready handshake.
- Clears the downstream serial comparator, then shifts both operands out MSB-first on `a`/`b`, one bit per clock.
- Pulses `done` when the comparator's `eq`/`gt`/`lt` result is final; it sits between operand-producing logic and the serial comparator.

---
 rtl/comparator_stream_tx.sv | 102 ++++++++++
 tb/tb_comparator_stream_tx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/comparator_stream_tx.sv
// Serial compare transmitter: accepts an operand pair, clears the downstream
// comparator for GAP cycles, then streams both operands MSB-first.
module comparator_stream_tx #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned GAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             a,
    output logic             b,
    output logic             bit_valid,
    output logic             last,
    output logic             cmp_rst_n,
    output logic             done
);

    localparam int unsigned MAX_WG = (WIDTH > GAP) ? WIDTH : GAP;
    localparam int unsigned CW     = $clog2(MAX_WG) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d;
    logic [WIDTH-1:0] shb_q, shb_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sha_q   <= '0;
            shb_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sha_d   = in_a;
                    shb_d   = in_b;
                    cnt_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (cnt_q == CW'(GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                // Shift by operator rather than slicing so WIDTH=1 elaborates.
                sha_d = sha_q << 1;
                shb_d = shb_q << 1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        cmp_rst_n = (state_q != S_CLEAR);
        bit_valid = (state_q == S_SHIFT);
        a         = (state_q == S_SHIFT) & sha_q[WIDTH-1];
        b         = (state_q == S_SHIFT) & shb_q[WIDTH-1];
        last      = (state_q == S_SHIFT) && (cnt_q == CW'(WIDTH - 1));
        done      = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_comparator_stream_tx.sv
// Bench for comparator_stream_tx: two configurations (4/1 and 8/3) checked
// against operand-level expectations and a serial comparator model.
module tb_comparator_stream_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       drv_valid = 1'b0;
    logic [7:0] drv_a = '0;
    logic [7:0] drv_b = '0;
    logic       sel = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    logic r4, a4, b4, bv4, l4, c4, d4;
    logic r8, a8, b8, bv8, l8, c8, d8;
    logic o_ready, o_a, o_b, o_bv, o_last, o_crn, o_done;

    comparator_stream_tx #(.WIDTH(4), .GAP(1)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(drv_valid & ~sel), .in_ready(r4),
        .in_a(drv_a[3:0]), .in_b(drv_b[3:0]), .a(a4), .b(b4), .bit_valid(bv4),
        .last(l4), .cmp_rst_n(c4), .done(d4)
    );

    comparator_stream_tx #(.WIDTH(8), .GAP(3)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(drv_valid & sel), .in_ready(r8),
        .in_a(drv_a), .in_b(drv_b), .a(a8), .b(b8), .bit_valid(bv8),
        .last(l8), .cmp_rst_n(c8), .done(d8)
    );

    assign o_ready = sel ? r8  : r4;
    assign o_a     = sel ? a8  : a4;
    assign o_b     = sel ? b8  : b4;
    assign o_bv    = sel ? bv8 : bv4;
    assign o_last  = sel ? l8  : l4;
    assign o_crn   = sel ? c8  : c4;
    assign o_done  = sel ? d8  : d4;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset_values();
        check("rst_ready", o_ready, 1);
        check("rst_a", o_a, 0);
        check("rst_b", o_b, 0);
        check("rst_bv", o_bv, 0);
        check("rst_last", o_last, 0);
        check("rst_crn", o_crn, 1);
        check("rst_done", o_done, 0);
    endtask

    // One frame on the selected DUT. hold keeps in_valid high with (na,nb)
    // after acceptance; mut_idx changes in_a during that shift bit;
    // abort_idx applies reset during that shift bit.
    task automatic frame(input logic [7:0] fa, input logic [7:0] fb,
                         input bit hold, input logic [7:0] na, input logic [7:0] nb,
                         input int mut_idx, input logic [7:0] mut_a,
                         input int abort_idx, output int acc_cyc);
        int w, g, waitn, cmp, refc;
        w = sel ? 8 : 4;
        g = sel ? 3 : 1;
        drv_valid = 1'b1;
        drv_a = fa;
        drv_b = fb;
        waitn = 0;
        while (o_ready !== 1'b1 && waitn < 40) begin
            step();
            waitn++;
        end
        check("accept_wait", o_ready, 1);
        step();
        acc_cyc = cyc;
        if (hold) begin
            drv_a = na;
            drv_b = nb;
        end else begin
            drv_valid = 1'b0;
        end
        cmp = 0;
        for (int i = 0; i < g; i++) begin
            check("clr_crn", o_crn, 0);
            check("clr_ready", o_ready, 0);
            check("clr_bv", o_bv, 0);
            if (o_crn === 1'b0) cmp = 0;
            step();
        end
        for (int i = 0; i < w; i++) begin
            check("sh_bv", o_bv, 1);
            check("sh_a", o_a, fa[w-1-i]);
            check("sh_b", o_b, fb[w-1-i]);
            check("sh_last", o_last, (i == w - 1));
            check("sh_ready", o_ready, 0);
            check("sh_crn", o_crn, 1);
            check("sh_done", o_done, 0);
            if (cmp == 0 && o_a === 1'b1 && o_b === 1'b0) cmp = 1;
            else if (cmp == 0 && o_a === 1'b0 && o_b === 1'b1) cmp = 2;
            if (i == mut_idx) drv_a = mut_a;
            if (i == abort_idx) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                drv_valid = 1'b0;
                check_reset_values();
                for (int j = 0; j < 12; j++) begin
                    step();
                    check("abort_no_done", o_done, 0);
                end
                return;
            end
            step();
        end
        refc = (fa > fb) ? 1 : ((fa < fb) ? 2 : 0);
        check("done", o_done, 1);
        check("done_bv", o_bv, 0);
        check("done_a", o_a, 0);
        check("done_b", o_b, 0);
        check("done_ready", o_ready, 0);
        check("cmp_result", cmp, refc);
        step();
        check("ret_ready", o_ready, 1);
        check("ret_done", o_done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc1, acc2, n;
        logic [7:0] ra, rb;

        reset = 1'b1;
        step();
        sel = 1'b0;
        check_reset_values();
        sel = 1'b1;
        check_reset_values();
        sel = 1'b0;
        step();
        reset = 1'b0;
        step();

        // 4-bit / GAP 1 directed frames
        frame(8'h6, 8'hC, 1'b0, 8'h0, 8'h0, -1, 8'h0, -1, acc1);
        frame(8'hA, 8'hA, 1'b0, 8'h0, 8'h0, -1, 8'h0, -1, acc1);
        frame(8'h6, 8'hC, 1'b1, 8'hC, 8'h6, -1, 8'h0, -1, acc1);
        frame(8'hC, 8'h6, 1'b0, 8'h0, 8'h0, -1, 8'h0, -1, acc2);
        check("b2b_spacing", acc2 - acc1, 7);
        frame(8'h6, 8'hC, 1'b1, 8'h6, 8'hC, 1, 8'hF, -1, acc1);
        frame(8'hF, 8'hC, 1'b0, 8'h0, 8'h0, -1, 8'h0, -1, acc2);
        check("mut_spacing", acc2 - acc1, 7);
        frame(8'h9, 8'h3, 1'b0, 8'h0, 8'h0, -1, 8'h0, 1, acc1);
        frame(8'h3, 8'h9, 1'b0, 8'h0, 8'h0, -1, 8'h0, -1, acc1);

        for (int k = 0; k < 20; k++) begin
            ra = 8'($urandom_range(0, 15));
            rb = (k % 4 == 0) ? ra : 8'($urandom_range(0, 15));
            frame(ra, rb, 1'b0, 8'h0, 8'h0, -1, 8'h0, -1, acc1);
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) step();
        end

        // 8-bit / GAP 3 frames
        sel = 1'b1;
        step();
        frame(8'hFF, 8'h00, 1'b0, 8'h0, 8'h0, -1, 8'h0, -1, acc1);
        for (int k = 0; k < 10; k++) begin
            ra = 8'($urandom);
            rb = (k % 5 == 0) ? ra : 8'($urandom);
            frame(ra, rb, 1'b0, 8'h0, 8'h0, -1, 8'h0, -1, acc1);
        end
        frame(8'h5A, 8'hA5, 1'b0, 8'h0, 8'h0, -1, 8'h0, 4, acc1);
        frame(8'h80, 8'h7F, 1'b0, 8'h0, 8'h0, -1, 8'h0, -1, acc1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
